// File: rtl/deflate_selftest_ctrl.sv
// Self-test sequencer for the deflate core: writes an LFSR pattern, starts compression,
// waits for done with a timeout, reads the output back and checks length and checksum.
module deflate_selftest_ctrl #(
    parameter int unsigned N_BYTES    = 64,
    parameter logic [7:0]  SEED       = 8'hA5,
    parameter logic [15:0] EXP_LEN    = 16'd0,
    parameter logic [15:0] EXP_SUM    = 16'd0,
    parameter int unsigned TIMEOUT    = 1048576,
    parameter int unsigned RD_LAT     = 2,
    parameter bit          AUTO_START = 1'b1,
    parameter int unsigned BLINK_BITS = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [2:0]  core_mode,
    output logic [7:0]  core_data,
    output logic [15:0] core_waddr,
    output logic [15:0] core_raddr,
    input  logic        core_done,
    input  logic [15:0] core_oprogress,
    input  logic [7:0]  core_byte,
    output logic        busy,
    output logic [1:0]  status,
    output logic        led_r,
    output logic        led_g,
    output logic        led_b,
    output logic        o_led
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW = 17;

    localparam logic [2:0] MODE_IDLE   = 3'd0;
    localparam logic [2:0] MODE_WRITE  = 3'd1;
    localparam logic [2:0] MODE_READ   = 3'd2;
    localparam logic [2:0] MODE_STARTC = 3'd3;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_EMPTY    = 2'd2;
    localparam logic [1:0] ST_MISMATCH = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE, S_WRITE, S_START, S_WAIT, S_READ, S_DRAIN, S_CHECK, S_PASS, S_FAIL
    } state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           idx, idx_d;
    logic [TW-1:0]           wait_cnt, wait_d;
    logic [2:0]              drain_cnt, drain_d;
    logic [7:0]              lfsr, lfsr_d;
    logic [15:0]             sum, sum_d;
    logic [15:0]             len, len_d;
    logic [RD_LAT-1:0]       rd_pipe;
    logic [BLINK_BITS-1:0]   blink, blink_d;
    logic [2:0]              mode_d;
    logic [7:0]              data_d;
    logic [15:0]             waddr_d, raddr_d;
    logic [1:0]              status_d;
    logic                    busy_d;
    logic                    begin_pass;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    assign o_led = blink[BLINK_BITS-1];

    // Next-state and next-output logic; outputs are registered alongside the state.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        wait_d     = wait_cnt;
        drain_d    = drain_cnt;
        lfsr_d     = lfsr;
        len_d      = len;
        status_d   = status;
        mode_d     = MODE_IDLE;
        data_d     = core_data;
        waddr_d    = core_waddr;
        raddr_d    = core_raddr;
        begin_pass = 1'b0;
        blink_d    = blink + BLINK_BITS'(1);
        sum_d      = rd_pipe[RD_LAT-1] ? sum + 16'(core_byte) : sum;

        case (state)
            S_IDLE: begin
                if (AUTO_START || start) begin_pass = 1'b1;
            end
            S_WRITE: begin
                if (idx < CW'(N_BYTES)) begin
                    mode_d  = MODE_WRITE;
                    waddr_d = idx[15:0];
                    data_d  = lfsr;
                    lfsr_d  = lfsr_next(lfsr);
                    idx_d   = idx + CW'(1);
                end else begin
                    state_d = S_START;
                    mode_d  = MODE_STARTC;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                // The first two WAIT cycles may still see done from a previous pass.
                if (core_done && (32'(wait_cnt) >= 32'd2)) begin
                    len_d = core_oprogress;
                    if (core_oprogress == 16'd0) begin
                        state_d  = S_FAIL;
                        status_d = ST_EMPTY;
                    end else begin
                        state_d = S_READ;
                        mode_d  = MODE_READ;
                        raddr_d = 16'd0;
                        idx_d   = CW'(1);
                    end
                end else if (32'(wait_cnt) == TIMEOUT - 32'd1) begin
                    state_d  = S_FAIL;
                    status_d = ST_TIMEOUT;
                end else begin
                    wait_d = wait_cnt + TW'(1);
                end
            end
            S_READ: begin
                if (idx < {1'b0, len}) begin
                    mode_d  = MODE_READ;
                    raddr_d = idx[15:0];
                    idx_d   = idx + CW'(1);
                end else begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == 3'(RD_LAT - 1)) state_d = S_CHECK;
                else                             drain_d = drain_cnt + 3'd1;
            end
            S_CHECK: begin
                if (len == EXP_LEN && sum == EXP_SUM) begin
                    state_d  = S_PASS;
                    status_d = ST_OK;
                end else begin
                    state_d  = S_FAIL;
                    status_d = ST_MISMATCH;
                end
            end
            S_PASS, S_FAIL: begin
                if (start) begin_pass = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A new pass emits byte 0 straight away so WRITE runs one byte per cycle.
        if (begin_pass) begin
            state_d  = S_WRITE;
            mode_d   = MODE_WRITE;
            waddr_d  = 16'd0;
            data_d   = SEED;
            lfsr_d   = lfsr_next(SEED);
            idx_d    = CW'(1);
            sum_d    = 16'd0;
            len_d    = 16'd0;
            wait_d   = '0;
            status_d = ST_OK;
        end

        busy_d = (state_d inside {S_WRITE, S_START, S_WAIT, S_READ, S_DRAIN, S_CHECK});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            wait_cnt   <= '0;
            drain_cnt  <= '0;
            lfsr       <= '0;
            sum        <= '0;
            len        <= '0;
            rd_pipe    <= '0;
            blink      <= '0;
            core_mode  <= MODE_IDLE;
            core_data  <= '0;
            core_waddr <= '0;
            core_raddr <= '0;
            busy       <= 1'b0;
            status     <= ST_OK;
            led_r      <= 1'b0;
            led_g      <= 1'b0;
            led_b      <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            wait_cnt   <= wait_d;
            drain_cnt  <= drain_d;
            lfsr       <= lfsr_d;
            sum        <= sum_d;
            len        <= len_d;
            blink      <= blink_d;
            core_mode  <= mode_d;
            core_data  <= data_d;
            core_waddr <= waddr_d;
            core_raddr <= raddr_d;
            busy       <= busy_d;
            status     <= status_d;
            led_r      <= (state_d == S_FAIL);
            led_g      <= (state_d == S_PASS);
            led_b      <= busy_d & blink_d[BLINK_BITS-1];
            // Marks the cycle whose core_byte belongs to an issued read address.
            rd_pipe[0] <= (core_mode == MODE_READ);
            for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

endmodule

// File: tb/tb_deflate_selftest_ctrl.sv
// Randomized self-checking bench for deflate_selftest_ctrl with a behavioural core model.
module tb_deflate_selftest_ctrl;

    localparam int unsigned N_BYTES    = 4;
    localparam logic [7:0]  SEED       = 8'hA5;
    localparam logic [15:0] EXP_LEN    = 16'd3;
    localparam logic [15:0] EXP_SUM    = 16'd6;
    localparam int unsigned TIMEOUT    = 100;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned BLINK_BITS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  core_mode;
    logic [7:0]  core_data;
    logic [15:0] core_waddr, core_raddr;
    logic        core_done = 1'b0;
    logic [15:0] core_oprogress = 16'd0;
    logic [7:0]  core_byte;
    logic        busy, led_r, led_g, led_b, o_led;
    logic [1:0]  status;

    int n_checks = 0;
    int n_fail   = 0;
    int hb;

    logic [7:0] out_mem [0:255];
    logic [7:0] rd_pipe [0:RD_LAT-1];

    deflate_selftest_ctrl #(
        .N_BYTES(N_BYTES), .SEED(SEED), .EXP_LEN(EXP_LEN), .EXP_SUM(EXP_SUM),
        .TIMEOUT(TIMEOUT), .RD_LAT(RD_LAT), .AUTO_START(1'b1), .BLINK_BITS(BLINK_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .core_mode(core_mode), .core_data(core_data),
        .core_waddr(core_waddr), .core_raddr(core_raddr),
        .core_done(core_done), .core_oprogress(core_oprogress), .core_byte(core_byte),
        .busy(busy), .status(status),
        .led_r(led_r), .led_g(led_g), .led_b(led_b), .o_led(o_led)
    );

    always #5 clk = ~clk;

    // Core output memory with RD_LAT cycles of read latency.
    always @(posedge clk) begin
        rd_pipe[0] <= out_mem[core_raddr[7:0]];
        for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign core_byte = rd_pipe[RD_LAT-1];

    // Cycles since reset release, for the heartbeat expectation.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hb <= 0;
        else        hb <= hb + 1;
    end

    function automatic logic [7:0] model_lfsr(input logic [7:0] v);
        int x;
        int fb;
        x  = int'(v);
        fb = ((x >> 7) + (x >> 5) + (x >> 4) + (x >> 3)) % 2;
        return 8'(((x * 2) + fb) % 256);
    endfunction

    function automatic logic hb_msb();
        return 1'((hb >> (BLINK_BITS - 1)) % 2);
    endfunction

    // Runs one pass from the first WRITE cycle up to PASS/FAIL and checks it end to end.
    task automatic run_pass(input bit kick, input bit stale, input int dly, input int len,
                            input bit poke_write, input bit poke_end, input string name);
        int ws = -1;
        int wr = 0, sc = 0, rd = 0, res = -1;
        int w, w0, expw, exp_rd, s;
        logic [1:0] expst;
        logic [7:0] lf, last_data;
        lf = SEED;
        last_data = 8'h00;
        s = 0;
        for (int i = 0; i < len; i++) s = s + int'(out_mem[i]);
        s = s % 65536;
        w0 = (dly < 2) ? 2 : dly;
        if (dly >= int'(TIMEOUT)) begin
            expst = 2'd1; expw = int'(TIMEOUT); exp_rd = 0;
        end else if (len == 0) begin
            expst = 2'd2; expw = w0 + 1; exp_rd = 0;
        end else begin
            expst = (len == int'(EXP_LEN) && s == int'(EXP_SUM)) ? 2'd0 : 2'd3;
            expw = w0 + 1 + len + int'(RD_LAT) + 1;
            exp_rd = len;
        end
        core_done = stale;
        core_oprogress = 16'd0;
        if (kick) start = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (led_g || led_r) begin
                res = c - ws;
                break;
            end
            n_checks++;
            if (busy !== 1'b1 || led_b !== hb_msb()) begin
                n_fail++;
                $display("FAIL %s busy/led_b: got %b/%b want 1/%b", name, busy, led_b, hb_msb());
            end
            n_checks++;
            if (o_led !== hb_msb()) begin
                n_fail++;
                $display("FAIL %s o_led: got %b want %b", name, o_led, hb_msb());
            end
            case (core_mode)
                3'd1: begin
                    n_checks++;
                    if (core_waddr !== 16'(wr) || core_data !== lf) begin
                        n_fail++;
                        $display("FAIL %s write %0d: got addr %0d data %h want addr %0d data %h",
                                 name, wr, core_waddr, core_data, wr, lf);
                    end
                    last_data = lf;
                    lf = model_lfsr(lf);
                    wr++;
                    if (poke_write && wr == 2) start = 1'b1;
                end
                3'd3: begin
                    sc++;
                    ws = c + 1;
                end
                3'd2: begin
                    n_checks++;
                    if (core_raddr !== 16'(rd)) begin
                        n_fail++;
                        $display("FAIL %s raddr: got %0d want %0d", name, core_raddr, rd);
                    end
                    rd++;
                end
                3'd0: ;
                default: begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s core_mode: got %0d want 0..3", name, core_mode);
                end
            endcase
            if (ws >= 0 && c >= ws) begin
                w = c - ws;
                if (w >= dly) begin
                    core_done = 1'b1; core_oprogress = 16'(len);
                end else if (stale && w < 2) begin
                    core_done = 1'b1; core_oprogress = 16'd0;
                end else begin
                    core_done = 1'b0;
                end
                if (poke_end && w == expw - 1) start = 1'b1;
            end
        end
        n_checks++;
        if (res !== expw) begin
            n_fail++;
            $display("FAIL %s result cycle: got %0d want %0d", name, res, expw);
        end
        n_checks++;
        if (wr !== int'(N_BYTES) || sc !== 1 || rd !== exp_rd) begin
            n_fail++;
            $display("FAIL %s counts: got wr=%0d startc=%0d rd=%0d want wr=%0d startc=1 rd=%0d",
                     name, wr, sc, rd, N_BYTES, exp_rd);
        end
        n_checks++;
        if (status !== expst || led_g !== (expst == 2'd0) || led_r !== (expst != 2'd0)) begin
            n_fail++;
            $display("FAIL %s status: got st=%0d g=%b r=%b want st=%0d", name, status, led_g, led_r, expst);
        end
        n_checks++;
        if (busy !== 1'b0 || core_mode !== 3'd0 || led_b !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle outputs: got busy=%b mode=%0d led_b=%b want 0/0/0", name, busy, core_mode, led_b);
        end
        n_checks++;
        if (core_waddr !== 16'(N_BYTES - 1) || core_data !== last_data ||
            (exp_rd > 0 && core_raddr !== 16'(exp_rd - 1))) begin
            n_fail++;
            $display("FAIL %s held addr/data: got w=%0d d=%h r=%0d want w=%0d d=%h",
                     name, core_waddr, core_data, core_raddr, N_BYTES - 1, last_data);
        end
        if (poke_end) begin
            repeat (3) @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || status !== expst || led_g !== (expst == 2'd0) || led_r !== (expst != 2'd0)) begin
                n_fail++;
                $display("FAIL %s start at result entry: got busy=%b st=%0d want busy=0 st=%0d", name, busy, status, expst);
            end
        end
    endtask

    task automatic set_mem3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        out_mem[0] = a; out_mem[1] = b; out_mem[2] = c;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({core_mode, core_data, core_waddr, core_raddr, busy, status, led_r, led_g, led_b, o_led} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got mode=%0d busy=%b st=%0d leds=%b%b%b%b want all 0",
                     core_mode, busy, status, led_r, led_g, led_b, o_led);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pass();
        set_mem3(8'h01, 8'h02, 8'h03);
        run_pass(1'b0, 1'b0, 9, 3, 1'b0, 1'b1, "pass");
    endtask

    task automatic test_mismatch();
        set_mem3(8'h01, 8'h02, 8'h04);
        run_pass(1'b1, 1'b0, 9, 3, 1'b1, 1'b0, "mismatch");
    endtask

    task automatic test_restart();
        set_mem3(8'h01, 8'h02, 8'h03);
        run_pass(1'b1, 1'b0, 9, 3, 1'b0, 1'b0, "restart");
    endtask

    task automatic test_timeout();
        run_pass(1'b1, 1'b0, 100000, 3, 1'b0, 1'b1, "timeout");
    endtask

    task automatic test_empty();
        run_pass(1'b1, 1'b0, 5, 0, 1'b0, 1'b0, "empty");
    endtask

    task automatic test_stale_done();
        set_mem3(8'h01, 8'h02, 8'h03);
        run_pass(1'b1, 1'b1, 10, 3, 1'b0, 1'b0, "stale_done");
    endtask

    task automatic test_done_boundary();
        set_mem3(8'h02, 8'h02, 8'h02);
        run_pass(1'b1, 1'b0, int'(TIMEOUT) - 1, 3, 1'b0, 1'b0, "done_last_cycle");
        run_pass(1'b1, 1'b0, int'(TIMEOUT), 3, 1'b0, 1'b0, "done_too_late");
        run_pass(1'b1, 1'b0, 0, 3, 1'b0, 1'b0, "done_immediate");
    endtask

    task automatic test_random();
        int len, dly;
        for (int k = 0; k < 10; k++) begin
            len = $urandom_range(0, 5);
            for (int i = 0; i < 8; i++) out_mem[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) begin
                len = 3;
                out_mem[0] = 8'($urandom_range(0, 6));
                out_mem[1] = 8'($urandom_range(0, 6 - int'(out_mem[0])));
                out_mem[2] = 8'(6 - int'(out_mem[0]) - int'(out_mem[1]));
            end
            dly = ($urandom_range(0, 3) == 0) ? $urandom_range(95, 110) : $urandom_range(0, 20);
            run_pass(1'b1, 1'($urandom_range(0, 1)), dly, len, 1'($urandom_range(0, 1)), 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_read();
        bit found = 1'b0;
        set_mem3(8'h01, 8'h02, 8'h03);
        core_done = 1'b1;
        core_oprogress = 16'd3;
        start = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (core_mode === 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_mid_read: got no READ cycle want READ within 100 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({core_mode, core_data, core_waddr, core_raddr, busy, status, led_r, led_g, led_b, o_led} !== '0) begin
            n_fail++;
            $display("FAIL async reset: got mode=%0d raddr=%0d busy=%b want all 0", core_mode, core_raddr, busy);
        end
        core_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (core_mode !== 3'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL held reset: got mode=%0d busy=%b want 0/0", core_mode, busy);
            end
        end
        rst_n = 1'b1;
        run_pass(1'b0, 1'b0, 9, 3, 1'b1, 1'b0, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) out_mem[i] = 8'h00;
        test_reset();
        test_pass();
        test_mismatch();
        test_restart();
        test_timeout();
        test_empty();
        test_stale_done();
        test_done_boundary();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test want end within 2 ms");
        $fatal(1);
    end

endmodule
